// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - per-scanline sprite selection and renderer dispatch
module sprite_line_scheduler #(
    parameter int NUM_SPRITES  = 8,
    parameter int DIMENSION    = 8,
    parameter int MAX_PER_LINE = 4,
    parameter int COORD_W      = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           attr_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] attr_addr,
    input  logic                           attr_en,
    input  logic [COORD_W-1:0]             attr_x,
    input  logic [COORD_W-1:0]             attr_y,
    input  logic                           hblank_start,
    input  logic [COORD_W-1:0]             next_line,
    output logic                           draw_start,
    output logic [$clog2(NUM_SPRITES)-1:0] draw_id,
    output logic [COORD_W-1:0]             draw_x,
    output logic [$clog2(DIMENSION)-1:0]   draw_row,
    input  logic                           draw_done,
    output logic                           line_done,
    output logic                           busy,
    output logic                           overflow,
    output logic                           late
);

    localparam int ID_W   = $clog2(NUM_SPRITES);
    localparam int ROW_W  = $clog2(DIMENSION);
    localparam int CNT_W  = $clog2(MAX_PER_LINE + 1);
    localparam int SLOT_N = 1 << CNT_W;
    localparam int SLOT_W = ID_W + COORD_W + ROW_W;

    localparam logic [COORD_W:0]   DIM_EXT  = (COORD_W + 1)'(DIMENSION);
    localparam logic [ID_W-1:0]    LAST_IDX = ID_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_PER_LINE);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        AWAIT_DONE,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Attribute table
    logic               en_tab [NUM_SPRITES];
    logic [COORD_W-1:0] x_tab  [NUM_SPRITES];
    logic [COORD_W-1:0] y_tab  [NUM_SPRITES];

    // Per-line working state
    logic [COORD_W-1:0] line_q;
    logic [ID_W-1:0]    scan_idx;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   issue_idx;
    logic [SLOT_W-1:0]  slot [SLOT_N];

    // Entry currently under evaluation
    logic               cur_en;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [COORD_W:0]   y_end;
    logic [ROW_W-1:0]   cur_row;
    logic [SLOT_W-1:0]  cur_slot;
    logic               hit;
    logic               room;
    logic               take;
    logic               scan_last;
    logic [CNT_W-1:0]   issue_next;

    // Table reads use the registered value, so a same-cycle write is seen only by later scans.
    always_comb begin
        cur_en    = en_tab[scan_idx];
        cur_x     = x_tab[scan_idx];
        cur_y     = y_tab[scan_idx];
        // One extra bit keeps y + DIMENSION from wrapping near the bottom of the coordinate space.
        y_end     = {1'b0, cur_y} + DIM_EXT;
        hit       = cur_en && (line_q >= cur_y) && ({1'b0, line_q} < y_end);
        // Only the low bits of the difference are needed; they depend only on the low operand bits.
        cur_row   = line_q[ROW_W-1:0] - cur_y[ROW_W-1:0];
        cur_slot  = {scan_idx, cur_x, cur_row};
        room      = count < MAX_CNT;
        take      = (state == SCAN) && hit && room;
        scan_last = scan_idx == LAST_IDX;
        issue_next = issue_idx + 1'b1;
    end

    // Host writes to the attribute table, accepted in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                en_tab[i] <= 1'b0;
                x_tab[i]  <= '0;
                y_tab[i]  <= '0;
            end
        end else if (attr_we) begin
            en_tab[attr_addr] <= attr_en;
            x_tab[attr_addr]  <= attr_x;
            y_tab[attr_addr]  <= attr_y;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (hblank_start) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                if (scan_last) begin
                    next_state = ((count != '0) || take) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                next_state = AWAIT_DONE;
            end
            AWAIT_DONE: begin
                if (draw_done) begin
                    next_state = (issue_next == count) ? DONE : ISSUE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status outputs decode straight from the state so reset clears them without waiting for a clock.
    always_comb begin
        draw_start = (state == ISSUE);
        line_done  = (state == DONE);
        busy       = (state != IDLE);
    end

    // Scan bookkeeping, slot list and the held draw descriptor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q    <= '0;
            scan_idx  <= '0;
            count     <= '0;
            issue_idx <= '0;
            overflow  <= 1'b0;
            late      <= 1'b0;
            draw_id   <= '0;
            draw_x    <= '0;
            draw_row  <= '0;
            for (int i = 0; i < SLOT_N; i++) begin
                slot[i] <= '0;
            end
        end else begin
            if (hblank_start && (state != IDLE)) begin
                late <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (hblank_start) begin
                        line_q    <= next_line;
                        scan_idx  <= '0;
                        count     <= '0;
                        issue_idx <= '0;
                        overflow  <= 1'b0;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + 1'b1;
                    if (hit) begin
                        if (room) begin
                            slot[count] <= cur_slot;
                            count       <= count + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    // The first descriptor may be the hit being stored this very cycle.
                    if (scan_last && (next_state == ISSUE)) begin
                        if (take && (count == '0)) begin
                            {draw_id, draw_x, draw_row} <= cur_slot;
                        end else begin
                            {draw_id, draw_x, draw_row} <= slot[0];
                        end
                    end
                end
                AWAIT_DONE: begin
                    if (draw_done) begin
                        issue_idx <= issue_next;
                        if (issue_next != count) begin
                            {draw_id, draw_x, draw_row} <= slot[issue_next];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline scheduler that shares one sprite renderer between NUM_SPRITES sprite slots.
- On each horizontal-blank pulse it scans a sprite attribute table (enable, x, y) and selects up to MAX_PER_LINE sprites that intersect the next line.
- It then dispatches the selected sprites to the renderer one at a time with a start/done handshake.
- It sits between the host-written attribute registers and the sprite controller/line-buffer path feeding VGA_R/G/B.

Parameters:
- NUM_SPRITES, 8, number of attribute table entries (power of 2, >= 2).
- DIMENSION, 8, sprite height/width in pixels (power of 2).
- MAX_PER_LINE, 4, maximum sprites rendered per scanline (1..NUM_SPRITES).
- COORD_W, 10, width of x/y/line coordinates.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- attr_we  in  1  attribute table write strobe.
- attr_addr  in  $clog2(NUM_SPRITES)  entry written.
- attr_en  in  1  sprite enable written.
- attr_x  in  COORD_W  sprite left x written.
- attr_y  in  COORD_W  sprite top y written.
- hblank_start  in  1  one-cycle pulse; begin scheduling for next_line.
- next_line  in  COORD_W  scanline to be prepared, sampled with hblank_start.
- draw_start  out  1  one-cycle request to renderer.
- draw_id  out  $clog2(NUM_SPRITES)  sprite index being dispatched.
- draw_x  out  COORD_W  x of dispatched sprite.
- draw_row  out  $clog2(DIMENSION)  row within sprite = line - y.
- draw_done  in  1  renderer finished current sprite.
- line_done  out  1  one-cycle pulse, all work for the line complete.
- busy  out  1  high in any state except IDLE.
- overflow  out  1  more than MAX_PER_LINE hits on the last scanned line.
- late  out  1  sticky: hblank_start arrived while busy.

Behaviour:
- Reset (async) values:
  - State IDLE; all outputs 0.
  - Attribute table cleared (all attr_en=0, x=y=0).
  - Slot list and counters 0.
- Attribute table:
  - Write on clk edge when attr_we; visible to the scan from the next cycle.
  - Writes are accepted in every state.
  - A write to an entry the scan has already passed affects the next line only.
- FSM states: IDLE, SCAN, ISSUE, AWAIT_DONE, DONE.
- IDLE:
  - On hblank_start, latch next_line into line_q.
  - Clear slot count, scan index and overflow; go to SCAN.
- SCAN:
  - Evaluates one entry per cycle, index 0..NUM_SPRITES-1, so it lasts exactly NUM_SPRITES cycles.
  - Hit condition: en && line_q >= y && line_q < y + DIMENSION. The sum is computed at COORD_W+1 bits, so no wrap-around; a sprite near max y never wraps to line 0.
  - On a hit with count < MAX_PER_LINE: store {index, x, line_q - y (low bits)} in slot[count] and increment count.
  - On a hit with count == MAX_PER_LINE: set overflow and discard the hit.
  - Priority is strictly ascending index.
  - After the last index, go to ISSUE if count > 0, else DONE.
- ISSUE:
  - draw_start=1 for exactly this cycle.
  - draw_id/draw_x/draw_row = slot[issue_idx]; these outputs hold stable until the next ISSUE.
  - Go to AWAIT_DONE.
- AWAIT_DONE:
  - draw_done is sampled only in this state; it is ignored in all other states.
  - On draw_done, increment issue_idx. If issue_idx+1 == count go to DONE, else ISSUE.
  - No timeout: the state waits indefinitely.
- DONE: line_done=1 for one cycle, then IDLE.
- Latency:
  - hblank_start at cycle T.
  - SCAN occupies T+1..T+NUM_SPRITES.
  - First draw_start at T+NUM_SPRITES+1.
  - With zero hits, line_done at T+NUM_SPRITES+1.
- Simultaneous events:
  - hblank_start while busy (including the DONE cycle) is ignored and sets late. late is cleared only by reset.
  - attr_we and a scan of the same entry in the same cycle: the scan uses the old value.
- overflow holds its value until the next accepted hblank_start.
- Reset mid-operation: immediate return to IDLE; no pending draw_start or line_done is emitted.

Test Plan:
- Reset, no writes, hblank_start with next_line=5 -> no draw_start; line_done exactly 9 cycles after the pulse (T+9); overflow=0.
- Sprites 2 (y=10,x=40) and 6 (y=14,x=100) enabled, next_line=15:
  - draw_start with id=2, x=40, row=5; then after draw_done, id=6, x=100, row=1.
  - line_done the cycle after the second AWAIT_DONE exit.
- All 8 sprites enabled at y=0, next_line=7 -> ids 0,1,2,3 dispatched in order; overflow=1.
- Boundary: y=1016, next_line=1023 -> hit, row=7. With next_line=0 -> no hit (no wrap). With y=20, next_line=28 -> no hit.
- hblank_start during AWAIT_DONE -> ignored, late=1 and stays 1. draw_done pulsed during ISSUE or IDLE -> no index advance.
- Assert reset while in AWAIT_DONE:
  - busy=0 and draw_start=0 immediately (asynchronously).
  - Table cleared; the next hblank_start yields zero hits.
